// File: rtl/scaler_engine.sv
`default_nettype none
// ============================================================================
//  Module   : scaler_engine
//  Purpose  : Frame resize engine. Streams a SRC_W x SRC_H frame out of the
//             source RAM and writes a copied, upscaled, decimated or
//             block-averaged frame into the destination RAM.
//  Revision : 1.0  initial release
// ============================================================================
module scaler_engine #(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int MAX_W  = 640,
    parameter int MAX_H  = 480,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        factor_sel,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              wr_en,
    output logic [9:0]        out_width,
    output logic [9:0]        out_height,
    output logic              busy,
    output logic              done,
    output logic              frame_ready,
    output logic              cfg_err
);

    localparam int ACC_W = PIX_W + 6;

    localparam logic [1:0]        c_mode_copy = 2'b00;
    localparam logic [1:0]        c_mode_up   = 2'b01;
    localparam logic [1:0]        c_mode_dec  = 2'b10;
    localparam logic [1:0]        c_mode_avg  = 2'b11;
    localparam logic [ADDR_W-1:0] c_src_w     = ADDR_W'(SRC_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    // start synchroniser and edge detect
    logic r_sync0, r_sync1, r_start_prev;
    logic w_pulse;

    // latched configuration
    logic [1:0] r_mode, r_fsel;
    logic [1:0] w_fsh;              // log2 of the scale factor
    logic [2:0] w_fm1;              // factor minus one
    logic [ADDR_W-1:0] w_f;         // factor as an address step
    logic [ADDR_W-1:0] w_row_step;  // F source rows
    logic [31:0] w_w, w_h;
    logic w_cfg_ok, w_is_avg;

    // read-side counters
    logic              r_rd_act;
    logic [9:0]        r_ox, r_oy;
    logic [2:0]        r_fx, r_fy;
    logic [ADDR_W-1:0] r_sx, r_row, r_dyoff;
    logic w_xend, w_yend, w_sub_x_end, w_sub_y_end, w_pix_end, w_last_rd;

    // return / write pipeline
    logic              r_p1_v, r_p1_first, r_p1_end, r_p1_final;
    logic              r_p2_v, r_p2_final;
    logic [ACC_W-1:0]  r_acc, w_acc_sum;
    logic [PIX_W-1:0]  r_avg_q;
    logic [ADDR_W-1:0] r_waddr;
    logic              w_wr_last;
    logic              r_busy, r_frame_ready, r_cfg_err;
    logic [9:0]        r_out_w, r_out_h;

    assign w_pulse  = r_sync1 & ~r_start_prev;
    assign w_is_avg = (r_mode == c_mode_avg);
    assign w_fsh    = r_fsel + 2'd1;

    // factor-derived steps and the candidate output dimensions
    always_comb begin
        w_fm1 = 3'd7;
        case (w_fsh)
            2'd1:    w_fm1 = 3'd1;
            2'd2:    w_fm1 = 3'd3;
            default: w_fm1 = 3'd7;
        endcase
        w_f        = ADDR_W'(w_fm1) + ADDR_W'(1);
        w_row_step = c_src_w << w_fsh;
        w_w = 32'(SRC_W);
        w_h = 32'(SRC_H);
        case (r_mode)
            c_mode_copy: begin w_w = 32'(SRC_W);          w_h = 32'(SRC_H);          end
            c_mode_up:   begin w_w = 32'(SRC_W) << w_fsh; w_h = 32'(SRC_H) << w_fsh; end
            default:     begin w_w = 32'(SRC_W) >> w_fsh; w_h = 32'(SRC_H) >> w_fsh; end
        endcase
        w_cfg_ok = (r_fsel != 2'b11) && (w_w <= 32'(MAX_W)) && (w_h <= 32'(MAX_H));
    end

    assign w_xend      = (r_ox == r_out_w - 10'd1);
    assign w_yend      = (r_oy == r_out_h - 10'd1);
    assign w_sub_x_end = (r_fx == w_fm1);
    assign w_sub_y_end = (r_fy == w_fm1);
    assign w_pix_end   = w_is_avg ? (w_sub_x_end && w_sub_y_end) : 1'b1;
    assign w_last_rd   = w_pix_end && w_xend && w_yend;

    // the first sample of each block reloads the accumulator
    assign w_acc_sum = (r_p1_first ? '0 : r_acc) + ACC_W'(rd_data);

    assign rd_addr = r_rd_act ? (r_row + r_dyoff + r_sx + (w_is_avg ? ADDR_W'(r_fx) : '0)) : '0;

    assign wr_en     = w_is_avg ? r_p2_v : r_p1_v;
    assign w_wr_last = w_is_avg ? r_p2_final : r_p1_final;
    assign wr_addr   = r_waddr;
    assign wr_data   = wr_en ? (w_is_avg ? r_avg_q : rd_data) : '0;

    assign out_width   = r_out_w;
    assign out_height  = r_out_h;
    assign busy        = r_busy;
    assign done        = (r_state == S_DONE);
    assign frame_ready = r_frame_ready;
    assign cfg_err     = r_cfg_err;

    // two-flop synchroniser plus previous-value flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0      <= 1'b0;
            r_sync1      <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_sync0      <= start;
            r_sync1      <= r_sync0;
            r_start_prev <= r_sync1;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // next-state logic; RUN ends on the cycle the final write is presented
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pulse) w_state_nxt = S_SETUP;
            S_SETUP: w_state_nxt = w_cfg_ok ? S_RUN : S_IDLE;
            S_RUN:   if (wr_en && w_wr_last) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // configuration latch, status flags and read-address counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= '0; r_fsel <= '0;
            r_out_w <= 10'(SRC_W); r_out_h <= 10'(SRC_H);
            r_busy <= 1'b0; r_frame_ready <= 1'b0; r_cfg_err <= 1'b0;
            r_rd_act <= 1'b0;
            r_ox <= '0; r_oy <= '0; r_fx <= '0; r_fy <= '0;
            r_sx <= '0; r_row <= '0; r_dyoff <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_pulse) begin
                    r_mode        <= mode;
                    r_fsel        <= factor_sel;
                    r_frame_ready <= 1'b0;
                    r_cfg_err     <= 1'b0;
                end
                S_SETUP: if (w_cfg_ok) begin
                    r_out_w  <= w_w[9:0];
                    r_out_h  <= w_h[9:0];
                    r_busy   <= 1'b1;
                    r_rd_act <= 1'b1;
                    r_ox <= '0; r_oy <= '0; r_fx <= '0; r_fy <= '0;
                    r_sx <= '0; r_row <= '0; r_dyoff <= '0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
                S_RUN: if (r_rd_act) begin
                    if (w_last_rd) r_rd_act <= 1'b0;
                    case (r_mode)
                        c_mode_copy: begin
                            if (w_xend) begin
                                r_ox <= '0; r_sx <= '0; r_oy <= r_oy + 10'd1;
                                r_row <= r_row + c_src_w;
                            end else begin
                                r_ox <= r_ox + 10'd1; r_sx <= r_sx + ADDR_W'(1);
                            end
                        end
                        c_mode_up: begin
                            if (w_xend) begin
                                r_ox <= '0; r_sx <= '0; r_fx <= '0; r_oy <= r_oy + 10'd1;
                                if (w_sub_y_end) begin
                                    r_fy  <= '0;
                                    r_row <= r_row + c_src_w;
                                end else begin
                                    r_fy <= r_fy + 3'd1;
                                end
                            end else begin
                                r_ox <= r_ox + 10'd1;
                                if (w_sub_x_end) begin
                                    r_fx <= '0; r_sx <= r_sx + ADDR_W'(1);
                                end else begin
                                    r_fx <= r_fx + 3'd1;
                                end
                            end
                        end
                        c_mode_dec: begin
                            if (w_xend) begin
                                r_ox <= '0; r_sx <= '0; r_oy <= r_oy + 10'd1;
                                r_row <= r_row + w_row_step;
                            end else begin
                                r_ox <= r_ox + 10'd1; r_sx <= r_sx + w_f;
                            end
                        end
                        default: begin
                            if (!w_sub_x_end) begin
                                r_fx <= r_fx + 3'd1;
                            end else begin
                                r_fx <= '0;
                                if (!w_sub_y_end) begin
                                    r_fy    <= r_fy + 3'd1;
                                    r_dyoff <= r_dyoff + c_src_w;
                                end else begin
                                    r_fy <= '0; r_dyoff <= '0;
                                    if (w_xend) begin
                                        r_ox <= '0; r_sx <= '0; r_oy <= r_oy + 10'd1;
                                        r_row <= r_row + w_row_step;
                                    end else begin
                                        r_ox <= r_ox + 10'd1; r_sx <= r_sx + w_f;
                                    end
                                end
                            end
                        end
                    endcase
                end
                S_FLUSH: begin
                    r_busy        <= 1'b0;
                    r_frame_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // read-return pipeline, block accumulator and write address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1_v <= 1'b0; r_p1_first <= 1'b0; r_p1_end <= 1'b0; r_p1_final <= 1'b0;
            r_p2_v <= 1'b0; r_p2_final <= 1'b0;
            r_acc <= '0; r_avg_q <= '0; r_waddr <= '0;
        end else begin
            r_p1_v     <= (r_state == S_RUN) && r_rd_act;
            r_p1_first <= (r_fx == 3'd0) && (r_fy == 3'd0);
            r_p1_end   <= w_pix_end;
            r_p1_final <= w_last_rd;
            if (r_p1_v) r_acc <= w_acc_sum;
            r_p2_v     <= r_p1_v && r_p1_end && w_is_avg;
            r_p2_final <= r_p1_final;
            r_avg_q    <= PIX_W'(w_acc_sum >> {w_fsh, 1'b0});
            if (r_state == S_SETUP) r_waddr <= '0;
            else if (wr_en)         r_waddr <= r_waddr + ADDR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_scaler_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scaler_engine
//  Purpose  : Scoreboard bench for scaler_engine on a reduced 32x16 frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_scaler_engine;

    localparam int SW = 32, SH = 16, MW = 128, MH = 64, PW = 8, AW = 19;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0] mode = 2'b00, factor_sel = 2'b00;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [PW-1:0] rd_data, wr_data;
    logic wr_en, busy, done, frame_ready, cfg_err;
    logic [9:0] out_width, out_height;

    scaler_engine #(.SRC_W(SW), .SRC_H(SH), .MAX_W(MW), .MAX_H(MH),
                    .PIX_W(PW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .factor_sel(factor_sel),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_en(wr_en), .out_width(out_width), .out_height(out_height), .busy(busy),
        .done(done), .frame_ready(frame_ready), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    logic [7:0] src [0:SW*SH-1];
    logic [7:0] dst [0:MW*MH-1];

    // source RAM: data one cycle after address
    always @(posedge clk) rd_data <= src[rd_addr[8:0]];

    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    wr_t exp_q[$];
    wr_t e;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int wr_cnt = 0, first_wr = 0, last_wr = 0, done_cnt = 0, done_cyc = 0;

    always @(posedge clk) cyc++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // monitor: every write is popped against the scoreboard
    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
            dst[wr_addr[12:0]] = wr_data;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
    end

    // reference model of the whole output frame
    task automatic push_frame(input int m, input int f);
        int ow, oh, s;
        ow = (m == 0) ? SW : (m == 1) ? SW * f : SW / f;
        oh = (m == 0) ? SH : (m == 1) ? SH * f : SH / f;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++) begin
                case (m)
                    0: s = src[oy * SW + ox];
                    1: s = src[(oy / f) * SW + ox / f];
                    2: s = src[oy * f * SW + ox * f];
                    default: begin
                        s = 0;
                        for (int dy = 0; dy < f; dy++)
                            for (int dx = 0; dx < f; dx++)
                                s += src[(oy * f + dy) * SW + ox * f + dx];
                        s = s / (f * f);
                    end
                endcase
                exp_q.push_back({AW'(oy * ow + ox), 8'(s)});
            end
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [1:0] fs);
        @(negedge clk);
        mode = m; factor_sel = fs;
        wr_cnt = 0; done_cnt = 0;
        start_cyc = cyc;
        start = 1'b1;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) @(negedge clk);
        check("done_seen", 32'(done_cnt > 0), 32'd1);
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 5000 && wr_cnt < n; k++) @(negedge clk);
        check("writes_reached", 32'(wr_cnt >= n), 32'd1);
    endtask

    task automatic release_start();
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic reject_case(input logic [1:0] m, input logic [1:0] fs);
        start_frame(m, fs);
        repeat (4) @(negedge clk);
        check("rej_cfg_err", 32'(cfg_err), 32'd1);
        check("rej_busy", 32'(busy), 32'd0);
        check("rej_frame_ready", 32'(frame_ready), 32'd0);
        repeat (20) @(negedge clk);
        check("rej_writes", 32'(wr_cnt), 32'd0);
        check("rej_done", 32'(done_cnt), 32'd0);
        release_start();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < SW * SH; a++) src[a] = 8'(a);
        src[0] = 8'd10; src[1] = 8'd20; src[SW] = 8'd30; src[SW + 1] = 8'd41;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frame_ready", 32'(frame_ready), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_out_width", 32'(out_width), 32'd32);
        check("rst_out_height", 32'(out_height), 32'd16);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // copy
        push_frame(0, 1);
        start_frame(2'b00, 2'b00);
        wait_done(2000);
        check("copy_count", 32'(wr_cnt), 32'd512);
        check("copy_contiguous", 32'(last_wr - first_wr + 1), 32'd512);
        check("copy_first_latency", 32'(first_wr - start_cyc), 32'd5);
        check("copy_done_latency", 32'(done_cyc - last_wr), 32'd2);
        check("copy_frame_ready", 32'(frame_ready), 32'd1);
        check("copy_busy", 32'(busy), 32'd0);
        check("copy_pixel_300", 32'(dst[300]), 32'd44);
        check("copy_queue_empty", 32'(exp_q.size()), 32'd0);
        release_start();

        // upscale x4
        push_frame(1, 4);
        start_frame(2'b01, 2'b01);
        wait_done(10000);
        check("up4_count", 32'(wr_cnt), 32'd8192);
        check("up4_width", 32'(out_width), 32'd128);
        check("up4_height", 32'(out_height), 32'd64);
        check("up4_pixel_5_9", 32'(dst[1157]), 32'd65);
        check("up4_pixel_0", 32'(dst[0]), 32'd10);
        check("up4_first_latency", 32'(first_wr - start_cyc), 32'd5);
        check("up4_done_latency", 32'(done_cyc - last_wr), 32'd2);
        release_start();

        // reset in the middle of an upscale frame
        push_frame(1, 4);
        start_frame(2'b01, 2'b01);
        wait_writes(50);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_wr_en", 32'(wr_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frame_ready", 32'(frame_ready), 32'd0);
        check("midrst_out_width", 32'(out_width), 32'd32);
        check("midrst_out_height", 32'(out_height), 32'd16);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        release_start();

        // block average /2
        push_frame(3, 2);
        start_frame(2'b11, 2'b00);
        wait_done(3000);
        check("avg2_count", 32'(wr_cnt), 32'd128);
        check("avg2_width", 32'(out_width), 32'd16);
        check("avg2_height", 32'(out_height), 32'd8);
        check("avg2_pixel_0", 32'(dst[0]), 32'd25);
        check("avg2_spacing", 32'(last_wr - first_wr), 32'd508);
        check("avg2_done_latency", 32'(done_cyc - last_wr), 32'd2);
        release_start();

        // decimate /4
        push_frame(2, 4);
        start_frame(2'b10, 2'b01);
        wait_done(500);
        check("dec4_count", 32'(wr_cnt), 32'd32);
        check("dec4_width", 32'(out_width), 32'd8);
        check("dec4_pixel_1_1", 32'(dst[9]), 32'd132);
        release_start();

        // rejected requests
        reject_case(2'b01, 2'b10);
        reject_case(2'b10, 2'b11);

        // second start edge during RUN, with inputs changed mid-frame
        push_frame(0, 1);
        start_frame(2'b00, 2'b00);
        wait_writes(100);
        start = 1'b0; mode = 2'b11; factor_sel = 2'b10;
        repeat (3) @(negedge clk);
        start = 1'b1;
        wait_done(2000);
        repeat (30) @(negedge clk);
        check("dbl_done_pulses", 32'(done_cnt), 32'd1);
        check("dbl_count", 32'(wr_cnt), 32'd512);
        check("dbl_queue_empty", 32'(exp_q.size()), 32'd0);
        check("dbl_cfg_err_cleared", 32'(cfg_err), 32'd0);
        check("dbl_frame_ready", 32'(frame_ready), 32'd1);
        release_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
